// File: rtl/issueunit_int.sv
// Integer issue consumer: 1-cycle ALU plus MUL_LAT-deep multiplier broadcasting on one CDB.
// Latency 1 (ALU) / MUL_LAT (MULT); stalls the queue by withholding done when the CDB slot is taken.
module issueunit_int #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  issueint_opcode,
  input  logic [5:0]  issueint_rdtag,
  input  logic [31:0] issueint_rsdata,
  input  logic [31:0] issueint_rtdata,
  input  logic        issueint_ready,
  output logic        issueint_done,
  output logic [5:0]  cdb_tag,
  output logic [31:0] cdb_data,
  output logic        cdb_valid
);

  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_NOR  = 6'h27;
  localparam logic [5:0] OP_SLT  = 6'h2A;
  localparam logic [5:0] OP_SLLV = 6'h04;
  localparam logic [5:0] OP_SRLV = 6'h06;
  localparam logic [5:0] OP_SRAV = 6'h07;
  localparam logic [5:0] OP_MULT = 6'h18;

  localparam int NSTG = MUL_LAT - 1;

  logic              is_mul;
  logic              slot_busy;
  logic              alu_fire;
  logic              mul_fire;
  logic [MUL_LAT:1]  resv;
  logic [MUL_LAT:1]  resv_nxt;
  logic [31:0]       alu_res;
  logic [31:0]       mul_prod;
  logic [NSTG-1:0]   stg_vld;
  logic [5:0]        stg_tag [NSTG];
  logic [31:0]       stg_dat [NSTG];

  assign is_mul        = (issueint_opcode == OP_MULT);
  assign slot_busy     = is_mul ? resv[MUL_LAT] : resv[1];
  assign issueint_done = reset & issueint_ready & ~slot_busy;
  assign alu_fire      = issueint_done & ~is_mul;
  assign mul_fire      = issueint_done & is_mul;

  // A MULT accepted now completes MUL_LAT cycles out, i.e. MUL_LAT-1 ahead after this edge.
  always_comb begin
    resv_nxt              = {1'b0, resv[MUL_LAT:2]};
    resv_nxt[MUL_LAT-1]   = resv_nxt[MUL_LAT-1] | mul_fire;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resv <= '0;
    end else begin
      resv <= resv_nxt;
    end
  end

  // Low 32 bits of a product are the same for signed and unsigned operands.
  assign mul_prod = issueint_rsdata * issueint_rtdata;

  always_comb begin
    alu_res = 32'h0;
    case (issueint_opcode)
      OP_ADD:  alu_res = issueint_rsdata + issueint_rtdata;
      OP_SUB:  alu_res = issueint_rsdata - issueint_rtdata;
      OP_AND:  alu_res = issueint_rsdata & issueint_rtdata;
      OP_OR:   alu_res = issueint_rsdata | issueint_rtdata;
      OP_XOR:  alu_res = issueint_rsdata ^ issueint_rtdata;
      OP_NOR:  alu_res = ~(issueint_rsdata | issueint_rtdata);
      OP_SLT:  alu_res = {31'b0, $signed(issueint_rsdata) < $signed(issueint_rtdata)};
      OP_SLLV: alu_res = issueint_rtdata << issueint_rsdata[4:0];
      OP_SRLV: alu_res = issueint_rtdata >> issueint_rsdata[4:0];
      OP_SRAV: alu_res = $unsigned($signed(issueint_rtdata) >>> issueint_rsdata[4:0]);
      default: alu_res = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_vld <= '0;
      for (int i = 0; i < NSTG; i++) begin
        stg_tag[i] <= '0;
        stg_dat[i] <= '0;
      end
    end else begin
      stg_vld[0] <= mul_fire;
      stg_tag[0] <= issueint_rdtag;
      stg_dat[0] <= mul_prod;
      for (int i = 1; i < NSTG; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        stg_tag[i] <= stg_tag[i-1];
        stg_dat[i] <= stg_dat[i-1];
      end
    end
  end

  // The reservation vector guarantees alu_fire and the last multiplier stage never coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else if (alu_fire) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= issueint_rdtag;
      cdb_data  <= alu_res;
    end else if (stg_vld[NSTG-1]) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= stg_tag[NSTG-1];
      cdb_data  <= stg_dat[NSTG-1];
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_issueunit_int.sv
// Bench for issueunit_int: vector table plus hand sequences, CDB checked against a due-cycle scoreboard.
module tb_issueunit_int;

  localparam int MUL_LAT = 4;

  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_NOR  = 6'h27;
  localparam logic [5:0] OP_SLT  = 6'h2A;
  localparam logic [5:0] OP_SLLV = 6'h04;
  localparam logic [5:0] OP_SRLV = 6'h06;
  localparam logic [5:0] OP_SRAV = 6'h07;
  localparam logic [5:0] OP_MULT = 6'h18;

  logic        clk;
  logic        reset;
  logic [5:0]  issueint_opcode;
  logic [5:0]  issueint_rdtag;
  logic [31:0] issueint_rsdata;
  logic [31:0] issueint_rtdata;
  logic        issueint_ready;
  logic        issueint_done;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_valid;

  issueunit_int #(.MUL_LAT(MUL_LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .issueint_opcode (issueint_opcode),
    .issueint_rdtag  (issueint_rdtag),
    .issueint_rsdata (issueint_rsdata),
    .issueint_rtdata (issueint_rtdata),
    .issueint_ready  (issueint_ready),
    .issueint_done   (issueint_done),
    .cdb_tag         (cdb_tag),
    .cdb_data        (cdb_data),
    .cdb_valid       (cdb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic [5:0]  op;
    logic [5:0]  tag;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_done;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    int          due;
    logic [5:0]  tag;
    logic [31:0] data;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[19];
  int   cyc;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic check_cdb(input string name);
    int hit;
    hit = -1;
    foreach (sb[i]) if (sb[i].due == cyc) hit = i;
    if (hit >= 0) begin
      chk({name, ".cdb_valid"}, {31'b0, cdb_valid}, 32'd1);
      chk({name, ".cdb_tag"}, {26'b0, cdb_tag}, {26'b0, sb[hit].tag});
      chk({name, ".cdb_data"}, cdb_data, sb[hit].data);
      sb.delete(hit);
    end else begin
      chk({name, ".cdb_idle"}, {31'b0, cdb_valid}, 32'd0);
    end
  endtask

  // Called just after a rising edge; drives one cycle of stimulus and checks at the falling edge.
  task automatic step(input logic rst_v, input logic rdy, input logic [5:0] op,
                      input logic [5:0] tag, input logic [31:0] rs, input logic [31:0] rt,
                      input logic exp_done, input logic [31:0] exp_data, input string name);
    sb_t e;
    reset           = rst_v;
    issueint_ready  = rdy;
    issueint_opcode = op;
    issueint_rdtag  = tag;
    issueint_rsdata = rs;
    issueint_rtdata = rt;
    if (!rst_v) sb.delete();
    @(negedge clk);
    chk({name, ".done"}, {31'b0, issueint_done}, {31'b0, exp_done});
    check_cdb(name);
    if (exp_done) begin
      e.due  = cyc + ((op == OP_MULT) ? MUL_LAT : 1);
      e.tag  = tag;
      e.data = exp_data;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, OP_ADD, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0, "idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;

    tbl[0]  = '{1'b1, 1'b1, OP_ADD,  6'd1,  32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000};
    tbl[1]  = '{1'b1, 1'b1, OP_SUB,  6'd2,  32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF};
    tbl[2]  = '{1'b1, 1'b1, OP_AND,  6'd3,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000};
    tbl[3]  = '{1'b1, 1'b1, OP_OR,   6'd4,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hFFF0FFF0};
    tbl[4]  = '{1'b1, 1'b1, OP_XOR,  6'd5,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0FF00FF0};
    tbl[5]  = '{1'b1, 1'b1, OP_NOR,  6'd6,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h000F000F};
    tbl[6]  = '{1'b1, 1'b1, OP_SLT,  6'd7,  32'h00000005, 32'hFFFFFFFE, 1'b1, 32'h00000000};
    tbl[7]  = '{1'b1, 1'b1, OP_SLT,  6'd8,  32'h80000000, 32'h00000001, 1'b1, 32'h00000001};
    tbl[8]  = '{1'b1, 1'b1, OP_SLLV, 6'd9,  32'h00000024, 32'h0000000F, 1'b1, 32'h000000F0};
    tbl[9]  = '{1'b1, 1'b1, OP_SRLV, 6'd10, 32'h0000001F, 32'h80000000, 1'b1, 32'h00000001};
    tbl[10] = '{1'b1, 1'b1, OP_SRAV, 6'd11, 32'h00000008, 32'h80000000, 1'b1, 32'hFF800000};
    tbl[11] = '{1'b1, 1'b1, 6'h3F,   6'd12, 32'h00000001, 32'h00000002, 1'b1, 32'h00000000};
    tbl[12] = '{1'b1, 1'b0, OP_ADD,  6'd13, 32'h00000001, 32'h00000001, 1'b0, 32'h00000000};
    tbl[13] = '{1'b1, 1'b1, OP_MULT, 6'd14, 32'h00010000, 32'h00010000, 1'b1, 32'h00000000};
    tbl[14] = '{1'b1, 1'b1, OP_MULT, 6'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001};
    tbl[15] = '{1'b1, 1'b1, OP_ADD,  6'd16, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002};
    tbl[16] = '{1'b1, 1'b1, OP_ADD,  6'd17, 32'h00000001, 32'h00000002, 1'b0, 32'h00000003};
    tbl[17] = '{1'b1, 1'b1, OP_ADD,  6'd17, 32'h00000001, 32'h00000002, 1'b0, 32'h00000003};
    tbl[18] = '{1'b1, 1'b1, OP_ADD,  6'd17, 32'h00000001, 32'h00000002, 1'b1, 32'h00000003};

    reset           = 1'b0;
    issueint_ready  = 1'b1;
    issueint_opcode = OP_ADD;
    issueint_rdtag  = 6'd1;
    issueint_rsdata = 32'd1;
    issueint_rtdata = 32'd1;
    @(posedge clk);
    #1;

    // Reset held with a ready instruction offered.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, OP_ADD, 6'd1, 32'd1, 32'd1, 1'b0, 32'd0, "reset");
    chk("reset.cdb_tag", {26'b0, cdb_tag}, 32'd0);
    chk("reset.cdb_data", cdb_data, 32'd0);

    // ALU latency, accepted in the first cycle out of reset.
    step(1'b1, 1'b1, OP_ADD, 6'd5, 32'hFFFFFFFF, 32'd2, 1'b1, 32'h00000001, "alu_lat");
    idle(2);

    // MULT latency.
    step(1'b1, 1'b1, OP_MULT, 6'd9, 32'hFFFFFFFD, 32'd7, 1'b1, 32'hFFFFFFEB, "mul_lat");
    idle(5);

    for (int i = 0; i < 19; i++)
      step(tbl[i].rst_n, tbl[i].rdy, tbl[i].op, tbl[i].tag, tbl[i].rs, tbl[i].rt,
           tbl[i].exp_done, tbl[i].exp_data, $sformatf("vec%0d", i));
    idle(6);

    // CDB conflict: ALU wanting the MULT's completion slot waits one cycle.
    step(1'b1, 1'b1, OP_MULT, 6'd1, 32'd2, 32'd3, 1'b1, 32'd6, "conf.mul");
    idle(2);
    step(1'b1, 1'b1, OP_SLT, 6'd2, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd1, "conf.slt_held");
    step(1'b1, 1'b1, OP_SLT, 6'd2, 32'hFFFFFFFF, 32'd0, 1'b1, 32'd1, "conf.slt_acc");
    idle(3);

    // Three back-to-back MULTs push the shift out to the first free slot.
    for (int i = 1; i <= 3; i++)
      step(1'b1, 1'b1, OP_MULT, 6'(i), 32'd1, 32'(i), 1'b1, 32'(i), "b2b.mul");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, OP_SRAV, 6'd4, 32'd4, 32'h80000000, 1'b0, 32'hF8000000, "b2b.srav_held");
    step(1'b1, 1'b1, OP_SRAV, 6'd4, 32'd4, 32'h80000000, 1'b1, 32'hF8000000, "b2b.srav_acc");
    idle(3);

    // Reset mid-flight discards the pending MULT.
    step(1'b1, 1'b1, OP_MULT, 6'd7, 32'd3, 32'd3, 1'b1, 32'd9, "rstmf.mul");
    idle(1);
    step(1'b0, 1'b1, OP_ADD, 6'd6, 32'd1, 32'd1, 1'b0, 32'd2, "rstmf.rst");
    idle(4);

    // Same again, but an ALU offered right after release must not see the stale claim.
    step(1'b1, 1'b1, OP_MULT, 6'd8, 32'd3, 32'd3, 1'b1, 32'd9, "rstclr.mul");
    idle(1);
    step(1'b0, 1'b0, OP_ADD, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0, "rstclr.rst");
    step(1'b1, 1'b1, OP_ADD, 6'd9, 32'd4, 32'd5, 1'b1, 32'd9, "rstclr.alu");
    idle(6);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issueunit_int.md
Name: issueunit_int

Overview:
- Consumer end of the integer issue-queue interface. Pulls one ready instruction per cycle from the integer queue and executes it on a 1-cycle ALU or a pipelined multiplier.
- Broadcasts each result on the CDB (tag/data/valid) that the queues snoop.
- Owns CDB-slot scheduling so the ALU and multiplier never complete in the same cycle. A conflicting instruction is held in the queue by withholding issueint_done.

Parameters:
MUL_LAT, 4, multiplier issue-to-CDB latency in cycles; legal range 2..8.

Ports:
clk  input  1  clock, all flops rising edge
reset  input  1  asynchronous, active-low; 0 = reset asserted
issueint_opcode  input  6  function code of the offered instruction
issueint_rdtag  input  6  destination tag of the offered instruction
issueint_rsdata  input  32  rs operand
issueint_rtdata  input  32  rt operand
issueint_ready  input  1  queue offers a valid instruction with both operands resolved
issueint_done  output  1  combinational; instruction accepted this cycle, queue retires it at the next edge
cdb_tag  output  6  registered broadcast tag
cdb_data  output  32  registered broadcast data
cdb_valid  output  1  registered broadcast strobe

Behaviour:
- Opcodes (6-bit):
  - ADD 0x20: rs+rt, mod 2^32, no overflow trap.
  - SUB 0x22: rs-rt, mod 2^32.
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27: bitwise.
  - SLT 0x2A: signed compare, result 1 or 0.
  - SLLV 0x04, SRLV 0x06, SRAV 0x07: shift rt by rs[4:0].
  - MULT 0x18: low 32 bits of signed rs*rt.
  - Any other code: ALU class, result 0.
- Latency L(op): MULT = MUL_LAT; all others = 1. An instruction accepted in cycle t drives cdb_valid=1 with its rdtag and result during cycle t+L.
- CDB reservation vector resv[1..MUL_LAT]. resv[k]=1 means the CDB is claimed k cycles ahead.
- Accept rule: issueint_done = reset & issueint_ready & ~resv[L(issueint_opcode)]. No other stall source.
  - done never asserts while ready=0.
  - done never asserts while reset is asserted.
- Reservation update each edge: resv'[k] = resv[k+1] | (done & L==k+1) for k<MUL_LAT; resv'[MUL_LAT] = 0. A new claim lands on a slot that is already free by construction.
- ALU path:
  - Result, tag and valid are computed combinationally and registered at the edge ending the accept cycle.
  - The output register holds them for exactly one cycle.
- Multiplier path:
  - MUL_LAT-1 pipeline stages of {tag, product, valid} feed the output register.
  - Fully pipelined: back-to-back MULTs are accepted every cycle when slots are free.
- Output mux: at each edge, the CDB output register loads from whichever path completes next cycle. The schedule guarantees at most one source.
  - If neither path completes, cdb_valid' = 0; cdb_tag/cdb_data hold their previous values (don't-care).
- Reset values (asynchronous): cdb_valid=0, cdb_tag=0, cdb_data=0, resv all 0, all multiplier stage valids 0.
  - In-flight results are discarded with no replay; the queues are reset in the same event.
- Reset released mid-stream: first accept is possible in the first cycle with reset=1.
- Simultaneous events:
  - An ALU offered in cycle t while a MULT accepted in t-MUL_LAT+1 occupies slot t+1: done=0. The queue holds the instruction and it is accepted at t+1.
  - A MULT is blocked only if a prior claim exists at exactly MUL_LAT ahead. That cannot happen with single issue, so a MULT is always accepted when ready.
- Operand values are sampled only in the accept cycle; later input changes do not affect in-flight results.
- The CDB is driven one result per cycle maximum; continuous ALU issue yields cdb_valid=1 every cycle.

Test Plan:
- Reset: hold reset=0 with issueint_ready=1 -> done=0, cdb_valid=0, cdb_tag=0, cdb_data=0.
- ALU latency: release reset, offer ADD rs=0xFFFFFFFF rt=2 tag=5 at cycle 0 -> done=1 at cycle 0; cycle 1 cdb_valid=1, tag=5, data=0x00000001; cycle 2 cdb_valid=0.
- MULT latency (MUL_LAT=4): offer MULT rs=-3 rt=7 tag=9 at cycle 0 -> done=1; cdb_valid=1, tag=9, data=0xFFFFFFEB at cycle 4 only.
- CDB conflict:
  - Stimulus: MULT tag=1 at cycle 0, then SLT rs=-1 rt=0 tag=2 offered continuously from cycle 3.
  - Required: done=0 at cycle 3 and done=1 at cycle 4; CDB shows tag 1 at cycle 4 and tag 2 (data=1) at cycle 5.
- Back-to-back mix: MULT tags 1,2,3 in cycles 0-2, SRAV rs=4 rt=0x80000000 offered from cycle 3 -> SRAV accepted only at cycle 6; CDB tags 1,2,3 at cycles 4,5,6, then tag 4 with data 0xF8000000 at cycle 7.
- Reset mid-flight: MULT accepted at cycle 0, reset=0 pulse at cycle 2 -> cdb_valid stays 0 through cycle 6; resv cleared, so an ALU offered right after release is accepted immediately.
